// File: rtl/lenet_pkg.sv
// Shared LeNet fixed-point constants, pooled-map geometry and FC sequencer states.
package lenet_pkg;

  localparam int BITWIDTH  = 16;
  localparam int FRAC_BITS = 8;
  localparam int FC_IN_NUM = 50;
  localparam int POOL2_CH  = 2;
  localparam int POOL2_DIM = 5;

  typedef logic signed [BITWIDTH-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT,
    FIN
  } fc_state_t;

endpackage

// File: rtl/fc_round_sat.sv
// Floor-shift an accumulator back to BITWIDTH with saturation.
// Optional fused ReLU when FC_LAYER_RELU_EN is defined.
module fc_round_sat #(
  parameter int BITWIDTH  = lenet_pkg::BITWIDTH,
  parameter int FRAC_BITS = lenet_pkg::FRAC_BITS,
  parameter int ACC_WIDTH = 40
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [BITWIDTH-1:0]  result
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [BITWIDTH-1:0]  sat;

  always_comb begin
    shifted = sum >>> FRAC_BITS;
    if (shifted > MAX_V) begin
      sat = MAX_V[BITWIDTH-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[BITWIDTH-1:0];
    end else begin
      sat = shifted[BITWIDTH-1:0];
    end
`ifdef FC_LAYER_RELU_EN
    result = sat[BITWIDTH-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer after pool2: one MAC per cycle against external sync ROMs.
// FC_LAYER_RELU_EN (optional) fuses a ReLU into the output stage.
module fc_layer_seq #(
  parameter int BITWIDTH  = lenet_pkg::BITWIDTH,
  parameter int FRAC_BITS = lenet_pkg::FRAC_BITS,
  parameter int OUT_NUM   = 10,
  parameter int ACC_WIDTH = 40
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic signed [BITWIDTH-1:0]          featuremap_maxpooled [lenet_pkg::POOL2_CH-1:0][lenet_pkg::POOL2_DIM-1:0][lenet_pkg::POOL2_DIM-1:0],
  output logic [$clog2(OUT_NUM*50)-1:0]       w_addr,
  input  logic signed [BITWIDTH-1:0]          w_data,
  output logic [$clog2(OUT_NUM)-1:0]          b_addr,
  input  logic signed [BITWIDTH-1:0]          b_data,
  output logic                                busy,
  output logic                                out_valid,
  output logic [$clog2(OUT_NUM)-1:0]          out_idx,
  output logic signed [BITWIDTH-1:0]          out_data,
  output logic                                done
);

  import lenet_pkg::*;

  localparam int KW  = $clog2(FC_IN_NUM);
  localparam int WAW = $clog2(OUT_NUM*FC_IN_NUM);
  localparam int NW  = $clog2(OUT_NUM);

  fc_state_t                   state;
  logic [KW-1:0]               k;
  logic [NW-1:0]               n;
  logic signed [BITWIDTH-1:0]  map_q [FC_IN_NUM];
  logic signed [BITWIDTH-1:0]  elem_q;
  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [BITWIDTH-1:0]   result;

  // elem_q lags the address by one cycle so it lines up with the ROM's registered w_data.
  always_comb begin
    prod     = (2*BITWIDTH)'(elem_q) * (2*BITWIDTH)'(w_data);
    prod_ext = {{(ACC_WIDTH-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
    acc_next = acc + prod_ext;
    bias_ext = {{(ACC_WIDTH-BITWIDTH){b_data[BITWIDTH-1]}}, b_data} <<< FRAC_BITS;
    sum      = acc_next + bias_ext;
  end

  fc_round_sat #(
    .BITWIDTH (BITWIDTH),
    .FRAC_BITS(FRAC_BITS),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_round_sat (
    .sum   (sum),
    .result(result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      elem_q    <= '0;
      acc       <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      for (int a = 0; a < FC_IN_NUM; a++) begin
        map_q[a] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < POOL2_CH; c++) begin
              for (int i = 0; i < POOL2_DIM; i++) begin
                for (int j = 0; j < POOL2_DIM; j++) begin
                  map_q[c*POOL2_DIM*POOL2_DIM + i*POOL2_DIM + j] <= featuremap_maxpooled[c][i][j];
                end
              end
            end
            n      <= '0;
            k      <= '0;
            w_addr <= '0;
            b_addr <= '0;
            busy   <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          elem_q <= map_q[k];
          acc    <= (k == '0) ? '0 : acc_next;
          if (k == KW'(FC_IN_NUM-1)) begin
            state <= DRAIN;
          end else begin
            k      <= k + KW'(1);
            w_addr <= w_addr + WAW'(1);
          end
        end
        // Final product and bias fold straight into the registered result.
        DRAIN: begin
          acc       <= acc_next;
          out_data  <= result;
          out_idx   <= n;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (n == NW'(OUT_NUM-1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            n      <= n + NW'(1);
            k      <= '0;
            w_addr <= w_addr + WAW'(1);
            b_addr <= b_addr + NW'(1);
            state  <= MAC;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: directed maps/ROM contents with hand-computed results.
module tb_fc_layer_seq;
  import lenet_pkg::*;

  localparam int OUT_NUM = 10;
  localparam int WAW     = $clog2(OUT_NUM*FC_IN_NUM);
  localparam int NW      = $clog2(OUT_NUM);
  localparam int RUN_LEN = 52*OUT_NUM + 2;

`ifdef FC_LAYER_RELU_EN
  localparam int NEG_SAT = 0;
  localparam int NEG_896 = 0;
`else
  localparam int NEG_SAT = -32768;
  localparam int NEG_896 = -896;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [BITWIDTH-1:0] fmap [POOL2_CH-1:0][POOL2_DIM-1:0][POOL2_DIM-1:0];
  logic [WAW-1:0] w_addr;
  logic signed [BITWIDTH-1:0] w_data = '0;
  logic [NW-1:0] b_addr;
  logic signed [BITWIDTH-1:0] b_data = '0;
  logic busy, out_valid, done;
  logic [NW-1:0] out_idx;
  logic signed [BITWIDTH-1:0] out_data;

  fx_t w_rom [OUT_NUM*FC_IN_NUM];
  fx_t b_rom [OUT_NUM];

  typedef struct {
    int idx;
    int data;
    int cyc;
  } exp_t;

  exp_t sbq [$];
  int   done_q [$];
  exp_t mon_e;
  int   mon_d;
  int   exp_vals [OUT_NUM];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_c0 = 0;

  fc_layer_seq #(.OUT_NUM(OUT_NUM)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .featuremap_maxpooled(fmap),
    .w_addr              (w_addr),
    .w_data              (w_data),
    .b_addr              (b_addr),
    .b_data              (b_data),
    .busy                (busy),
    .out_valid           (out_valid),
    .out_idx             (out_idx),
    .out_data            (out_data),
    .done                (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models: data valid one cycle after the address.
  always @(posedge clk) begin
    w_data <= w_rom[w_addr];
    b_data <= b_rom[b_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_strobe", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("out_idx", int'(out_idx), mon_e.idx);
          checkOutput("out_data", int'(out_data), mon_e.data);
          checkOutput("strobe_cycle", cyc, mon_e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_d = done_q.pop_front();
          checkOutput("done_cycle", cyc, mon_d);
          checkOutput("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic set_map(input int v);
    for (int c = 0; c < POOL2_CH; c++)
      for (int i = 0; i < POOL2_DIM; i++)
        for (int j = 0; j < POOL2_DIM; j++)
          fmap[c][i][j] = BITWIDTH'(v);
  endtask

  task automatic set_roms(input int wv, input int bv);
    for (int a = 0; a < OUT_NUM*FC_IN_NUM; a++) w_rom[a] = BITWIDTH'(wv);
    for (int a = 0; a < OUT_NUM; a++) b_rom[a] = BITWIDTH'(bv);
  endtask

  task automatic set_exp(input int v);
    for (int n = 0; n < OUT_NUM; n++) exp_vals[n] = v;
  endtask

  task automatic push_run(input int c0);
    for (int n = 0; n < OUT_NUM; n++) begin
      sbq.push_back('{n, exp_vals[n], c0 + 52*(n+1)});
    end
    done_q.push_back(c0 + 52*OUT_NUM + 1);
  endtask

  task automatic applyStimulus(input bit hold);
    @(posedge clk);
    #1;
    start   = 1'b1;
    last_c0 = cyc;
    push_run(last_c0);
    if (!hold) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget && (sbq.size() != 0 || done_q.size() != 0); t++) begin
      @(negedge clk);
    end
    checkOutput("pending_after_timeout", sbq.size() + done_q.size(), 0);
    sbq.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    checkOutput("busy_after_run", int'(busy), 0);
  endtask

  initial begin
    set_map(0);
    set_roms(0, 0);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_out_idx", int'(out_idx), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_w_addr", int'(w_addr), 0);
    checkOutput("rst_b_addr", int'(b_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] ones x ones");
    set_map(256); set_roms(256, 0); set_exp(12800);
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] positive saturation");
    set_map(32512); set_roms(32512, 0); set_exp(32767);
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] negative saturation");
    set_roms(-32512, 0); set_exp(NEG_SAT);
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] bias only");
    set_map(300); set_roms(0, 0);
    for (int n = 0; n < OUT_NUM; n++) begin
      b_rom[n]    = BITWIDTH'(n*128);
      exp_vals[n] = n*128;
    end
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] negative bias");
    set_roms(0, -896); set_exp(NEG_896);
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] flatten order and addressing");
    set_map(0); set_roms(0, 0); set_exp(0);
    fmap[1][2][2] = 16'sd1000;
    fmap[0][1][3] = 16'sd500;
    w_rom[3*FC_IN_NUM + 37] = 16'sd256;
    w_rom[5*FC_IN_NUM + 8]  = 16'sd512;
    exp_vals[3] = 1000;
    exp_vals[5] = 1000;
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] start held, map changed mid-run");
    set_map(256); set_roms(256, 0); set_exp(12800);
    applyStimulus(1'b1);
    set_exp(25600);
    push_run(last_c0 + 52*OUT_NUM + 2);
    while (cyc < last_c0 + 100) @(posedge clk);
    #1;
    set_map(512);
    while (cyc < last_c0 + 52*OUT_NUM + 12) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(2*RUN_LEN + 10);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_third_run", int'(busy), 0);

    $display("[TB] reset mid-run");
    set_map(256); set_roms(256, 0); set_exp(12800);
    applyStimulus(1'b0);
    while (cyc < last_c0 + 80) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_out_data", int'(out_data), 0);
    checkOutput("abort_w_addr", int'(w_addr), 0);
    sbq.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(1'b0);
    wait_drain(RUN_LEN + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
